// File: rtl/ddr_rd_align.sv
// DDR read-capture aligner: finds which sample set and latency carry the
// read data, then delivers aligned two-beat words with a matching valid.
//
// Ports:
//   PCLK, RESET          clock, asynchronous active-high reset
//   iob_q   [4*WIDTH]    raw deserialiser samples, lane n sample k at 4*n+k
//   rd_en                one read word issued to memory this cycle
//   cal_req              pulse that starts a calibration run
//   rd_data [2*WIDTH]    aligned word, beat0 low half, beat1 high half
//   rd_valid             rd_data carries a returned word
//   cal_busy/done/fail   calibration status
//   cal_shift, cal_lat   chosen alignment and latency
module ddr_rd_align #(
    parameter int          WIDTH   = 16,
    parameter int          MAX_LAT = 15,
    parameter logic [3:0]  CAL_PAT = 4'b0110,
    parameter int          RETRIES = 4
) (
    input  logic                 PCLK,
    input  logic                 RESET,
    input  logic [4*WIDTH-1:0]   iob_q,
    input  logic                 rd_en,
    input  logic                 cal_req,
    output logic [2*WIDTH-1:0]   rd_data,
    output logic                 rd_valid,
    output logic                 cal_busy,
    output logic                 cal_done,
    output logic                 cal_fail,
    output logic [2:0]           cal_shift,
    output logic [3:0]           cal_lat
);

    localparam int CW = $clog2(MAX_LAT + 2);
    localparam int AW = $clog2(RETRIES + 1);

    localparam logic [WIDTH-1:0] P0 = {WIDTH{CAL_PAT[0]}};
    localparam logic [WIDTH-1:0] P1 = {WIDTH{CAL_PAT[1]}};
    localparam logic [WIDTH-1:0] P2 = {WIDTH{CAL_PAT[2]}};
    localparam logic [WIDTH-1:0] P3 = {WIDTH{CAL_PAT[3]}};

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SEARCH,
        DONE,
        FAIL
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] b0   [8];
    logic [WIDTH-1:0] b1   [8];
    logic [WIDTH-1:0] b1_q [4];

    logic [7:0] hit01, hit01_q, hit23, match;
    logic [2:0] sel;
    logic       any_match;

    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] att, att_n;
    logic [2:0]    shift_n;
    logic [3:0]    lat_n;

    logic               en;
    logic [MAX_LAT-1:0] dly;
    logic [MAX_LAT:0]   taps;

    // Candidates 0..3 pick a sample pair from this cycle; 4..7 reuse
    // the same pair but slip one beat, pairing last cycle's b1 with
    // this cycle's b0.
    always_comb begin
        b0 = '{default: '0};
        b1 = '{default: '0};
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < WIDTH; n++) begin
                b0[k][n] = iob_q[4*n + k];
                b1[k][n] = iob_q[4*n + (k ^ 2)];
            end
        end
        for (int k = 0; k < 4; k++) begin
            b0[k+4] = b1_q[k];
            b1[k+4] = b0[k];
        end
    end

    always_comb begin
        hit01 = '0;
        hit23 = '0;
        for (int s = 0; s < 8; s++) begin
            hit01[s] = (b0[s] == P0) && (b1[s] == P1);
            hit23[s] = (b0[s] == P2) && (b1[s] == P3);
        end
    end

    // The first pattern word is remembered as one flag per candidate,
    // so a match is simply "first word last cycle, second word now".
    assign match     = hit01_q & hit23;
    assign any_match = |match;

    always_comb begin
        sel = '0;
        for (int s = 7; s >= 0; s--) begin
            if (match[s]) sel = 3'(s);
        end
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            b1_q    <= '{default: '0};
            hit01_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) b1_q[k] <= b1[k];
            hit01_q <= hit01;
        end
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            att       <= '0;
            cal_shift <= '0;
            cal_lat   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            att       <= att_n;
            cal_shift <= shift_n;
            cal_lat   <= lat_n;
        end
    end

    // cnt equals the number of SEARCH cycles elapsed including the
    // current one, so the first pattern word sat at cycle cnt-1.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        att_n    = att;
        shift_n  = cal_shift;
        lat_n    = cal_lat;
        cal_busy = 1'b0;
        cal_done = 1'b0;
        cal_fail = 1'b0;
        unique case (state)
            IDLE, DONE, FAIL: begin
                cal_done = (state == DONE);
                cal_fail = (state == FAIL);
                if (cal_req) begin
                    state_n = ARM;
                    att_n   = '0;
                end
            end
            ARM: begin
                cal_busy = 1'b1;
                if (rd_en) begin
                    state_n = SEARCH;
                    cnt_n   = CW'(1);
                end
            end
            SEARCH: begin
                cal_busy = 1'b1;
                cnt_n    = cnt + CW'(1);
                if (any_match) begin
                    state_n = DONE;
                    shift_n = sel;
                    lat_n   = 4'(cnt - CW'(1));
                end else if (cnt == CW'(MAX_LAT + 1)) begin
                    att_n = att + AW'(1);
                    if (att_n < AW'(RETRIES)) begin
                        state_n = ARM;
                    end else begin
                        state_n = FAIL;
                        shift_n = '0;
                        lat_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Issued reads ride a delay line; tap cal_lat gives the cycle the
    // word is sampled, and the valid lands with the registered data.
    assign en   = rd_en && (state == DONE);
    assign taps = {dly, en};

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            dly      <= '0;
            rd_valid <= 1'b0;
        end else if (state_n != DONE) begin
            dly      <= '0;
            rd_valid <= 1'b0;
        end else begin
            dly      <= taps[MAX_LAT-1:0];
            rd_valid <= taps[cal_lat];
        end
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            rd_data <= '0;
        end else begin
            rd_data <= {b1[cal_shift], b0[cal_shift]};
        end
    end

endmodule

// File: tb/tb_ddr_rd_align.sv
// Directed bench for ddr_rd_align: calibration cases, normal-mode
// latency and ordering, failure after retries, and reset recovery.
module tb_ddr_rd_align;

    localparam int WIDTH = 16;

    logic               PCLK;
    logic               RESET;
    logic [4*WIDTH-1:0] iob_q;
    logic               rd_en;
    logic               cal_req;
    logic [2*WIDTH-1:0] rd_data;
    logic               rd_valid;
    logic               cal_busy;
    logic               cal_done;
    logic               cal_fail;
    logic [2:0]         cal_shift;
    logic [3:0]         cal_lat;

    int n_tests = 0;
    int n_fail  = 0;

    ddr_rd_align #(
        .WIDTH   (WIDTH),
        .MAX_LAT (15),
        .CAL_PAT (4'b0110),
        .RETRIES (4)
    ) dut (
        .PCLK      (PCLK),
        .RESET     (RESET),
        .iob_q     (iob_q),
        .rd_en     (rd_en),
        .cal_req   (cal_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .cal_fail  (cal_fail),
        .cal_shift (cal_shift),
        .cal_lat   (cal_lat)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [4*WIDTH-1:0] bc(input logic [3:0] nib);
        return {WIDTH{nib}};
    endfunction

    function automatic logic [15:0] wa(input int i);
        return 16'hA5C3 + 16'(i * 16'h1111);
    endfunction

    function automatic logic [15:0] wb(input int i);
        return 16'h3C5A ^ 16'(i * 16'h0F0F);
    endfunction

    // Place a word so alignment 1 (b0 on q1, b1 on q3) recovers it.
    function automatic logic [4*WIDTH-1:0] mk_s1(input logic [15:0] a,
                                                 input logic [15:0] b);
        logic [4*WIDTH-1:0] v;
        v = '0;
        for (int n = 0; n < WIDTH; n++) begin
            v[4*n+1] = a[n];
            v[4*n+3] = b[n];
        end
        return v;
    endfunction

    task automatic cal_seq(input string tag, input int first,
                           input logic [3:0] pre, input logic [3:0] w1,
                           input logic [3:0] w2, input logic [2:0] xs,
                           input logic [3:0] xl);
        iob_q   = '0;
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        check({tag, "_busy"}, cal_busy, 1);
        check({tag, "_done0"}, cal_done, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int k = 1; k <= first + 1; k++) begin
            if (k == first - 1)      iob_q = bc(pre);
            else if (k == first)     iob_q = bc(w1);
            else if (k == first + 1) iob_q = bc(w2);
            else                     iob_q = '0;
            tick();
        end
        iob_q = '0;
        check({tag, "_done"}, cal_done, 1);
        check({tag, "_idle"}, cal_busy, 0);
        check({tag, "_shift"}, cal_shift, xs);
        check({tag, "_lat"}, cal_lat, xl);
    endtask

    task automatic burst(input string tag, input int lat, input int n,
                         input bit chk_data);
        for (int cyc = 0; cyc < lat + n + 3; cyc++) begin
            rd_en = (cyc < n);
            if (chk_data && cyc >= lat && cyc < lat + n)
                iob_q = mk_s1(wa(cyc - lat), wb(cyc - lat));
            else
                iob_q = '0;
            tick();
            check({tag, "_valid"}, rd_valid,
                  (cyc >= lat && cyc < lat + n));
            if (chk_data && cyc >= lat && cyc < lat + n)
                check({tag, "_data"}, rd_data,
                      {wb(cyc - lat), wa(cyc - lat)});
        end
        rd_en = 1'b0;
        iob_q = '0;
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_data"}, rd_data, 0);
        check({tag, "_valid"}, rd_valid, 0);
        check({tag, "_busy"}, cal_busy, 0);
        check({tag, "_done"}, cal_done, 0);
        check({tag, "_fail"}, cal_fail, 0);
        check({tag, "_shift"}, cal_shift, 0);
        check({tag, "_lat"}, cal_lat, 0);
    endtask

    initial begin
        logic any_v;
        RESET   = 1'b1;
        iob_q   = '0;
        rd_en   = 1'b0;
        cal_req = 1'b0;
        tick();
        tick();
        zero_check("rst");
        RESET = 1'b0;

        // Pattern on q1/q3, three cycles after the read.
        cal_seq("c3", 3, 4'b0000, 4'b1000, 4'b0010, 3'd1, 4'd3);
        burst("b3", 3, 4, 1'b1);

        // Recalibrate from DONE to latency 6.
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        check("re_done_drop", cal_done, 0);
        check("re_busy", cal_busy, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            iob_q = (k == 6) ? bc(4'b1000) :
                    (k == 7) ? bc(4'b0010) : '0;
            tick();
        end
        iob_q = '0;
        check("c6_done", cal_done, 1);
        check("c6_shift", cal_shift, 1);
        check("c6_lat", cal_lat, 6);
        burst("b6", 6, 1, 1'b1);

        // Beat-slipped pattern: beat0 in last cycle, beat1 now.
        cal_seq("c5", 5, 4'b1000, 4'b1010, 4'b0000, 3'd7, 4'd5);
        burst("b5", 5, 2, 1'b0);

        // Match on the very cycle the search window closes.
        cal_seq("c15", 15, 4'b0000, 4'b1000, 4'b0010, 3'd1, 4'd15);
        burst("b15", 15, 2, 1'b1);

        // No pattern at all: four attempts then FAIL.
        any_v   = 1'b0;
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd_en = 1'b1;
            tick();
            if (a != 0) rd_en = 1'b0;
            for (int j = 1; j <= 16; j++) begin
                cal_req = (a == 1 && j == 5);
                tick();
                any_v = any_v | rd_valid;
            end
            cal_req = 1'b0;
            rd_en   = 1'b0;
            if (a < 3) begin
                check("f_busy", cal_busy, 1);
                check("f_early", cal_fail, 0);
            end
        end
        check("f_fail", cal_fail, 1);
        check("f_busy_end", cal_busy, 0);
        check("f_shift", cal_shift, 0);
        check("f_lat", cal_lat, 0);
        for (int j = 0; j < 6; j++) begin
            rd_en = (j < 3);
            tick();
            any_v = any_v | rd_valid;
        end
        rd_en = 1'b0;
        check("f_no_valid", any_v, 0);

        // Reset in the middle of a search.
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        iob_q = '1;
        tick();
        tick();
        check("pre_rst_busy", cal_busy, 1);
        #2;
        RESET = 1'b1;
        #1;
        zero_check("arst");
        tick();
        zero_check("rst2");
        iob_q = '0;
        RESET = 1'b0;
        cal_seq("c3r", 3, 4'b0000, 4'b1000, 4'b0010, 3'd1, 4'd3);
        burst("b3r", 3, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
